lopd_norm_pipe: RTL

LOPD_NORM_PIPE -- requirements
Module: lopd_norm_pipe

---
 rtl/lopd_norm_pipe_pkg.sv | 12 +
 rtl/lopd_norm_pipe_if.sv | 37 +++
 rtl/lopd_norm_pipe_tree.sv | 38 +++
 rtl/lopd_norm_pipe.sv | 112 +++++++++++
 4 files changed

// File: rtl/lopd_norm_pipe_pkg.sv
// Shared constants and helpers for the leading-one detect / normalise pipe.
// Operand width bounds and the position-field width function.
package lopd_norm_pipe_pkg;

  localparam int DATA_W_MIN = 4;
  localparam int DATA_W_MAX = 64;

  function automatic int pos_w(input int data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/lopd_norm_pipe_if.sv
// Operand/result handshake bundle for lopd_norm_pipe.
// slave is the pipe's view, master is the producer/consumer side.
interface lopd_norm_pipe_if #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 4
);
  import lopd_norm_pipe_pkg::*;

  localparam int POS_W = pos_w(DATA_W);

  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic [POS_W-1:0]  i_max_shift;
  logic [TAG_W-1:0]  i_tag;
  logic              o_valid;
  logic              i_ready;
  logic [POS_W-1:0]  o_pos_one;
  logic              o_zero_flag;
  logic [POS_W-1:0]  o_shift;
  logic              o_sat;
  logic [DATA_W-1:0] o_data_norm;
  logic [TAG_W-1:0]  o_tag;

  modport slave (
    input  i_valid, i_data, i_max_shift, i_tag, i_ready,
    output o_ready, o_valid, o_pos_one, o_zero_flag,
    output o_shift, o_sat, o_data_norm, o_tag
  );

  modport master (
    output i_valid, i_data, i_max_shift, i_tag, i_ready,
    input  o_ready, o_valid, o_pos_one, o_zero_flag,
    input  o_shift, o_sat, o_data_norm, o_tag
  );

endinterface

// File: rtl/lopd_norm_pipe_tree.sv
// Combinational leading-zero counter built by recursive halving.
// A zero operand yields an all-ones count and zero=1.
module lopd_tree #(
  parameter int W = 8,
  localparam int P = $clog2(W)
) (
  input  logic [W-1:0] d,
  output logic [P-1:0] lzc,
  output logic         zero
);

  if (W == 2) begin : g_leaf
    assign zero = ~|d;
    assign lzc  = ~d[1];
  end else begin : g_node
    logic [P-2:0] lh;
    logic [P-2:0] ll;
    logic         zh;
    logic         zl;

    lopd_tree #(.W(W/2)) u_hi (
      .d    (d[W-1:W/2]),
      .lzc  (lh),
      .zero (zh)
    );

    lopd_tree #(.W(W/2)) u_lo (
      .d    (d[W/2-1:0]),
      .lzc  (ll),
      .zero (zl)
    );

    // Empty upper half: count continues into the lower half.
    assign zero = zh & zl;
    assign lzc  = zh ? {1'b1, ll} : {1'b0, lh};
  end

endmodule

// File: rtl/lopd_norm_pipe.sv
// Two-stage leading-one detect and clamped left normalise.
// S1 registers operand + lzc, S2 registers the final result.
module lopd_norm_pipe
  import lopd_norm_pipe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 4
) (
  input logic             i_clk,
  input logic             i_rst,
  lopd_norm_pipe_if.slave bus
);

  localparam int POS_W = pos_w(DATA_W);

  logic              s1_adv;
  logic              s2_adv;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [POS_W-1:0]  s1_max;
  logic [TAG_W-1:0]  s1_tag;
  logic [POS_W-1:0]  s1_lzc;
  logic              s1_zero;

  logic              s2_valid;
  logic [POS_W-1:0]  s2_pos;
  logic              s2_zero;
  logic [POS_W-1:0]  s2_shift;
  logic              s2_sat;
  logic [DATA_W-1:0] s2_norm;
  logic [TAG_W-1:0]  s2_tag;

  logic [POS_W-1:0]  lzc;
  logic              zero;
  logic              sat_n;
  logic [POS_W-1:0]  shift_n;
  logic [DATA_W-1:0] norm_n;

  lopd_tree #(.W(DATA_W)) u_tree (
    .d    (bus.i_data),
    .lzc  (lzc),
    .zero (zero)
  );

  assign s2_adv      = ~s2_valid | bus.i_ready;
  assign s1_adv      = ~s1_valid | s2_adv;
  assign bus.o_ready = s1_adv & ~i_rst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_max   <= '0;
      s1_tag   <= '0;
      s1_lzc   <= '0;
      s1_zero  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        s1_data <= bus.i_data;
        s1_max  <= bus.i_max_shift;
        s1_tag  <= bus.i_tag;
        s1_lzc  <= lzc;
        s1_zero <= zero;
      end
    end
  end

  // Clamp to exponent headroom; a zero operand never shifts.
  always_comb begin
    sat_n   = ~s1_zero & (s1_lzc > s1_max);
    shift_n = s1_lzc;
    if (s1_zero) begin
      shift_n = '0;
    end else if (sat_n) begin
      shift_n = s1_max;
    end
    norm_n = s1_data << shift_n;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_valid <= 1'b0;
      s2_pos   <= '0;
      s2_zero  <= 1'b0;
      s2_shift <= '0;
      s2_sat   <= 1'b0;
      s2_norm  <= '0;
      s2_tag   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_pos   <= s1_lzc;
        s2_zero  <= s1_zero;
        s2_shift <= shift_n;
        s2_sat   <= sat_n;
        s2_norm  <= norm_n;
        s2_tag   <= s1_tag;
      end
    end
  end

  assign bus.o_valid     = s2_valid;
  assign bus.o_pos_one   = s2_pos;
  assign bus.o_zero_flag = s2_zero;
  assign bus.o_shift     = s2_shift;
  assign bus.o_sat       = s2_sat;
  assign bus.o_data_norm = s2_norm;
  assign bus.o_tag       = s2_tag;

endmodule
